// File: rtl/edge_gen_pkg.sv
// Shared types and constants for the edge generator.
package edge_gen_pkg;

    typedef enum logic [1:0] {
        LOW_IDLE  = 2'd0,
        LOW_HOLD  = 2'd1,
        HIGH_IDLE = 2'd2,
        HIGH_HOLD = 2'd3
    } edge_gen_state_t;

    localparam logic EDGE_RISE = 1'b1;
    localparam logic EDGE_FALL = 1'b0;

    // Hold timer width: enough for the larger minimum, never below 1 bit.
    function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/edge_gen_hold_timer.sv
// Loadable down-counter shared by both hold states; done flags a zero count.
module hold_timer #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_done_c
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/edge_gen.sv
// Edge generator: turns rise/fall requests into a level line with minimum high/low times.
// Optional edge counter enabled by defining EDGE_GEN_EDGE_CNT_EN.
module edge_gen
    import edge_gen_pkg::*;
#(
    parameter int unsigned MIN_HIGH = 4,
    parameter int unsigned MIN_LOW  = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_type,
    output logic             req_ready,
    output logic             d_out,
    output logic             busy,
    output logic             err_redundant
`ifdef EDGE_GEN_EDGE_CNT_EN
    ,
    output logic [CNT_W-1:0] edge_count
`endif
);

    localparam int unsigned TMR_W = tmr_width(MIN_HIGH, MIN_LOW);
    localparam logic [TMR_W-1:0] HIGH_LOAD = (MIN_HIGH > 1) ? TMR_W'(MIN_HIGH - 2) : '0;
    localparam logic [TMR_W-1:0] LOW_LOAD  = (MIN_LOW  > 1) ? TMR_W'(MIN_LOW  - 2) : '0;

    if (MIN_HIGH < 1 || MIN_LOW < 1 || CNT_W < 1) begin : g_bad_param
        $error("edge_gen: MIN_HIGH, MIN_LOW and CNT_W must all be >= 1");
    end

    edge_gen_state_t  r_state;
    edge_gen_state_t  w_state_n;
    logic             r_d_out;
    logic             w_d_out_n;
    logic             r_err;
    logic             w_err_n;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_load_val;
    logic             w_tmr_en;
    logic             w_tmr_done;

    hold_timer #(
        .W (TMR_W)
    ) u_hold_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .i_en       (w_tmr_en),
        .o_done_c   (w_tmr_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LOW_IDLE;
            r_d_out <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_d_out <= w_d_out_n;
            r_err   <= w_err_n;
        end
    end

    // Next state: real edges toggle and optionally start a hold, redundant ones only flag.
    always_comb begin
        w_state_n      = r_state;
        w_d_out_n      = r_d_out;
        w_err_n        = 1'b0;
        w_tmr_load     = 1'b0;
        w_tmr_load_val = '0;
        w_tmr_en       = 1'b0;
        case (r_state)
            LOW_IDLE: begin
                if (req_valid) begin
                    if (req_type == EDGE_RISE) begin
                        w_d_out_n = 1'b1;
                        if (MIN_HIGH > 1) begin
                            w_state_n      = HIGH_HOLD;
                            w_tmr_load     = 1'b1;
                            w_tmr_load_val = HIGH_LOAD;
                        end else begin
                            w_state_n = HIGH_IDLE;
                        end
                    end else begin
                        w_err_n = 1'b1;
                    end
                end
            end
            HIGH_IDLE: begin
                if (req_valid) begin
                    if (req_type == EDGE_FALL) begin
                        w_d_out_n = 1'b0;
                        if (MIN_LOW > 1) begin
                            w_state_n      = LOW_HOLD;
                            w_tmr_load     = 1'b1;
                            w_tmr_load_val = LOW_LOAD;
                        end else begin
                            w_state_n = LOW_IDLE;
                        end
                    end else begin
                        w_err_n = 1'b1;
                    end
                end
            end
            LOW_HOLD: begin
                if (w_tmr_done) w_state_n = LOW_IDLE;
                else            w_tmr_en  = 1'b1;
            end
            HIGH_HOLD: begin
                if (w_tmr_done) w_state_n = HIGH_IDLE;
                else            w_tmr_en  = 1'b1;
            end
            default: begin
                w_state_n = LOW_IDLE;
                w_d_out_n = 1'b0;
            end
        endcase
    end

    assign req_ready     = (r_state == LOW_IDLE) || (r_state == HIGH_IDLE);
    assign busy          = ~req_ready;
    assign d_out         = r_d_out;
    assign err_redundant = r_err;

`ifdef EDGE_GEN_EDGE_CNT_EN
    logic [CNT_W-1:0] r_edge_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge_cnt <= '0;
        end else if (w_d_out_n != r_d_out) begin
            r_edge_cnt <= r_edge_cnt + CNT_W'(1);
        end
    end

    assign edge_count = r_edge_cnt;
`endif

endmodule

// File: tb/tb_edge_gen.sv
// Randomized bench for edge_gen: two configurations (4/3 and 1/1) checked against a timing-window model.
module tb_edge_gen;

    logic clk;
    logic reset;
    logic req_valid;
    logic req_type;

    logic rdy_a, d_a, busy_a, err_a;
    logic rdy_b, d_b, busy_b, err_b;
    logic [1:0] ec_a, ec_b;

    int n_checks;
    int n_pass;

    // Model: level, earliest cycle a request may be accepted, pending error, toggle count.
    int   cyc;
    int   lvl     [2];
    int   next_ok [2];
    int   cnt     [2];
    logic exp_err [2];
    int   min_hi  [2];
    int   min_lo  [2];

    logic count_en;
    logic prev_b;
    int   pos_b;
    int   neg_b;

    edge_gen #(.MIN_HIGH(4), .MIN_LOW(3), .CNT_W(2)) u_dut_a (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_type      (req_type),
        .req_ready     (rdy_a),
        .d_out         (d_a),
        .busy          (busy_a),
        .err_redundant (err_a)
`ifdef EDGE_GEN_EDGE_CNT_EN
        ,
        .edge_count    (ec_a)
`endif
    );

    edge_gen #(.MIN_HIGH(1), .MIN_LOW(1), .CNT_W(2)) u_dut_b (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_type      (req_type),
        .req_ready     (rdy_b),
        .d_out         (d_b),
        .busy          (busy_b),
        .err_redundant (err_b)
`ifdef EDGE_GEN_EDGE_CNT_EN
        ,
        .edge_count    (ec_b)
`endif
    );

`ifndef EDGE_GEN_EDGE_CNT_EN
    assign ec_a = 2'd0;
    assign ec_b = 2'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    task automatic check_dut(input int k, input logic d, input logic rdy, input logic bsy,
                             input logic err, input logic [1:0] ec);
        logic ready_exp;
        ready_exp = (cyc >= next_ok[k]);
        chk($sformatf("d_out%0d", k), 32'(d), 32'(lvl[k]));
        chk($sformatf("req_ready%0d", k), 32'(rdy), 32'(ready_exp));
        chk($sformatf("busy%0d", k), 32'(bsy), 32'(!ready_exp));
        chk($sformatf("err_redundant%0d", k), 32'(err), 32'(exp_err[k]));
`ifdef EDGE_GEN_EDGE_CNT_EN
        chk($sformatf("edge_count%0d", k), 32'(ec), 32'(cnt[k] % 4));
`else
        if (ec !== 2'd0) chk("edge_count_tied", 32'(ec), 32'd0);
`endif
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            lvl[k]     = 0;
            next_ok[k] = cyc;
            cnt[k]     = 0;
            exp_err[k] = 1'b0;
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                lvl[k]     = 0;
                next_ok[k] = cyc + 1;
                cnt[k]     = 0;
                exp_err[k] = 1'b0;
            end else begin
                exp_err[k] = 1'b0;
                if (req_valid && (cyc >= next_ok[k])) begin
                    if (int'(req_type) != lvl[k]) begin
                        lvl[k]     = int'(req_type);
                        next_ok[k] = cyc + ((lvl[k] == 1) ? min_hi[k] : min_lo[k]);
                        cnt[k]     = cnt[k] + 1;
                    end else begin
                        exp_err[k] = 1'b1;
                        next_ok[k] = cyc + 1;
                    end
                end
            end
        end
        cyc++;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
    task automatic cycle(input logic rst, input logic v, input logic ty);
        reset     = rst;
        req_valid = v;
        req_type  = ty;
        @(negedge clk);
        check_dut(0, d_a, rdy_a, busy_a, err_a, ec_a);
        check_dut(1, d_b, rdy_b, busy_b, err_b, ec_b);
        if (count_en) begin
            if (d_b && !prev_b) pos_b++;
            if (!d_b && prev_b) neg_b++;
        end
        prev_b = d_b;
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        min_hi   = '{4, 1};
        min_lo   = '{3, 1};
        count_en = 1'b0;
        prev_b   = 1'b0;
        pos_b    = 0;
        neg_b    = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_type  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state, then a rise followed by a held fall request.
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        repeat (6) cycle(1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // Redundant fall while low.
        cycle(1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // Alternating requests; the 1/1 instance toggles every cycle.
        count_en = 1'b1;
        pos_b    = 0;
        neg_b    = 0;
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        count_en = 1'b0;
        chk("pos_pulses_b", 32'(pos_b), 32'd4);
        chk("neg_pulses_b", 32'(neg_b), 32'd4);

        // Single-cycle pulse inside a high hold.
        repeat (6) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 1'b0);

        // Reset asserted two cycles while in a high hold.
        repeat (6) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/edge_gen.md
Name: edge_gen

Overview:
Edge generator that drives a single level line from discrete rise/fall requests. It is the transmit side of an edge-detect link: a downstream edge detector sampling d_out on the same clk must see exactly one pos/neg pulse per accepted, non-redundant request. The block enforces a minimum high time and a minimum low time on d_out so every level is held long enough to be sampled.

Parameters:
MIN_HIGH, 4, minimum cycles d_out stays high after a rise; legal range >= 1
MIN_LOW, 4, minimum cycles d_out stays low after a fall; legal range >= 1
CNT_W, 8, width of the optional edge counter

Ports:
clk  input  1  single clock; all logic on posedge clk
reset  input  1  synchronous, active-high reset
req_valid  input  1  edge request valid
req_type  input  1  1 = rise (EDGE_RISE), 0 = fall (EDGE_FALL)
req_ready  output  1  block can accept a request this cycle
d_out  output  1  generated level line, registered
busy  output  1  equals ~req_ready
err_redundant  output  1  one-cycle pulse when an accepted request matches the current level
edge_count  output  CNT_W  toggle count; present only when EDGE_GEN_EDGE_CNT_EN is defined

Behaviour:
- Reset (synchronous, sampled on posedge clk):
  - State goes to LOW_IDLE; d_out=0, req_ready=1, busy=0, err_redundant=0.
  - Hold timer=0; edge_count=0.
  - Reset overrides any in-progress hold or request.
- States:
  - LOW_IDLE, LOW_HOLD, HIGH_IDLE, HIGH_HOLD.
  - d_out=1 in HIGH_*, 0 in LOW_*.
  - req_ready=1 only in *_IDLE.
- Handshake: a request is accepted in cycle t iff req_valid && req_ready in t. req_type is sampled only on acceptance. No request is buffered.
- Real edge (accepted in LOW_IDLE with rise, or in HIGH_IDLE with fall):
  - d_out toggles at the clk edge ending cycle t, so the new level is visible from t+1. Latency is 1 cycle.
  - If the new level's MIN > 1: enter the corresponding *_HOLD and load the timer with MIN-2. req_ready=0 for cycles t+1 .. t+MIN-1.
  - Return to *_IDLE so the earliest next acceptance is cycle t+MIN. The next toggle is then visible at t+MIN+1, so the level is held exactly MIN cycles under back-to-back requests.
  - If MIN == 1: go directly to the opposite *_IDLE. req_ready stays 1, and d_out can toggle every cycle.
- Redundant request (rise while high, or fall while low) in *_IDLE:
  - Accepted and consumed.
  - d_out and state are unchanged.
  - err_redundant=1 in cycle t+1 only; no hold is started.
- In *_HOLD, req_valid is ignored (no accept, no error). The requester must hold req_valid until ready.
- Timer decrements by 1 per cycle in *_HOLD. At 0 it moves to the matching *_IDLE. Timer width is $clog2(max(MIN_HIGH,MIN_LOW)) with a minimum of 1 bit.
- err_redundant and d_out are registered; there is no combinational path from req_* to d_out.
- req_ready is decoded from state only and does not depend on req_valid.

Optional Feature:
Macro EDGE_GEN_EDGE_CNT_EN.
- Defined: the edge_count port exists. It increments by 1 at every real toggle of d_out, rise or fall; redundant requests do not count. It wraps modulo 2^CNT_W and resets to 0.
- Undefined: the edge_count port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package edge_gen_pkg:
  - typedef enum logic [1:0] edge_gen_state_t {LOW_IDLE, LOW_HOLD, HIGH_IDLE, HIGH_HOLD}.
  - localparams EDGE_RISE=1'b1, EDGE_FALL=1'b0.
- Sub-module hold_timer: loadable down-counter with load, load_val, en, and done (count==0) outputs. One instance is shared by both hold states.
- FSM, output registers and the optional counter stay in edge_gen.

Test Plan:
- Reset: assert reset 2 cycles mid-stream while in HIGH_HOLD → next cycle d_out=0, req_ready=1, err_redundant=0, edge_count=0.
- MIN_HIGH=4, MIN_LOW=3; rise accepted at t=10, with req_valid held with fall → d_out=1 at 11..14, fall accepted at 14, d_out=0 at 15. req_ready=0 during 11..13.
- Redundant request: fall request while d_out=0 in LOW_IDLE → accepted, err_redundant=1 for exactly one cycle, d_out stays 0, edge_count unchanged.
- MIN_HIGH=MIN_LOW=1, alternating rise/fall with req_valid held 8 cycles → d_out toggles every cycle, req_ready constantly 1. A downstream edge detector reports 4 pos and 4 neg pulses.
- Requests during hold: MIN_HIGH=4, req_valid pulsed 1 cycle inside HIGH_HOLD → no acceptance, no error, d_out unchanged.
- With EDGE_GEN_EDGE_CNT_EN and CNT_W=2: 5 real edges → edge_count sequence 1,2,3,0,1.
